// File: rtl/atm_keypad_pkg.sv
// Shared constants and types for the ATM keypad entry stage: key codes, FSM states, digit width.
package atm_keypad_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad-side strobe inputs, downstream valid/ready field output, and status/debug signals.
// Handshake: a field transfers on any rising clk where entry_valid && entry_ready; entry_valid
// and entry_value hold steady until that cycle, and entry_valid never depends on entry_ready.
interface atm_keypad_entry_if #(
  parameter int DIGITS = 3
);
  import atm_keypad_pkg::*;

  localparam int VW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          entry_ready;
  logic          entry_valid;
  logic [VW-1:0] entry_value;
  logic [CW-1:0] digit_count;
  logic          entry_error;
  logic          entry_timeout;
  logic          busy;
  state_t        state;

  modport master (
    output key_valid, key_code, entry_ready,
    input  entry_valid, entry_value, digit_count, entry_error, entry_timeout, busy, state
  );

  modport slave (
    input  key_valid, key_code, entry_ready,
    output entry_valid, entry_value, digit_count, entry_error, entry_timeout, busy, state
  );

endinterface

// File: rtl/atm_inactivity_timer.sv
// Counts idle cycles while run is high; expire pulses on the last count unless a kick arrives.
module atm_inactivity_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt;

  // A kick in the terminal cycle wins, so expiry is masked by it.
  assign expire = run && !kick && (cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !run || kick || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad digit collector: packs DIGITS BCD digits (first typed in the MS nibble) and offers them
// on a valid/ready handshake. Define ATM_KEYPAD_TIMEOUT_EN to enable the inactivity auto-clear.
module atm_keypad_entry
  import atm_keypad_pkg::*;
#(
  parameter int          DIGITS         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_keypad_entry_if.slave    kp
);

  localparam int VW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t        state;
  logic [VW-1:0] value_q;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          error_q;
  logic          timeout_q;
  logic          busy_q;
  logic          expire;
  logic          full;

  assign full = (count_q == CW'(DIGITS));

`ifdef ATM_KEYPAD_TIMEOUT_EN
  atm_inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state == ENTRY),
    .kick   (kp.key_valid),
    .expire (expire)
  );
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      value_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (kp.key_valid) begin
            if (is_digit(kp.key_code)) begin
              value_q <= VW'(kp.key_code);
              count_q <= CW'(1);
              state   <= ENTRY;
              busy_q  <= 1'b1;
            end else if (kp.key_code != KEY_BKSP && kp.key_code != KEY_CLEAR) begin
              error_q <= 1'b1;
            end
          end
        end

        ENTRY: begin
          if (kp.key_valid) begin
            if (is_digit(kp.key_code)) begin
              if (full) begin
                error_q <= 1'b1;
              end else begin
                value_q <= (value_q << DIGIT_W) | VW'(kp.key_code);
                count_q <= count_q + CW'(1);
              end
            end else if (kp.key_code == KEY_BKSP) begin
              value_q <= value_q >> DIGIT_W;
              count_q <= count_q - CW'(1);
              if (count_q == CW'(1)) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else if (kp.key_code == KEY_CLEAR) begin
              value_q <= '0;
              count_q <= '0;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else if (kp.key_code == KEY_ENTER && full) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end else if (expire) begin
            value_q   <= '0;
            count_q   <= '0;
            state     <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end

        HOLD: begin
          // Keys are dropped silently here, including one in the transfer cycle.
          if (kp.entry_ready) begin
            valid_q <= 1'b0;
            value_q <= '0;
            count_q <= '0;
            state   <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          value_q <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign kp.entry_valid   = valid_q;
  assign kp.entry_value   = value_q;
  assign kp.digit_count   = count_q;
  assign kp.entry_error   = error_q;
  assign kp.entry_timeout = timeout_q;
  assign kp.busy          = busy_q;
  assign kp.state         = state;

endmodule
